joy2quad_accel: RTL and testbench

//  Multi-channel digital-joystick to quadrature-encoder emulator with hold-time acceleration.

---
 rtl/joy2quad_accel.sv | 148 ++++++++++++++
 tb/tb_joy2quad_accel.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/joy2quad_accel.sv
// Joystick-to-quadrature encoder emulator: per-channel Gray-code phase stepping whose
// step rate doubles after every ACCEL_STEPS steps held in one direction, up to MAX_SPEED.
module joy2quad_accel #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned ACCEL_STEPS = 8,
    parameter int unsigned MAX_SPEED   = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DIV_W-1:0]      clkdiv,
    input  logic [CHANNELS-1:0]   right,
    input  logic [CHANNELS-1:0]   left,
    output logic [2*CHANNELS-1:0] steer,
    output logic [CHANNELS-1:0]   moving
);

    localparam int unsigned SPD_W  = (MAX_SPEED > 0) ? $clog2(MAX_SPEED + 1) : 1;
    localparam int unsigned STEP_W = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ACCEL_STEPS - 1);
    localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(MAX_SPEED);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2
    } dir_t;

    // Right walks 00->10->11->01, left walks the same ring backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic to_right);
        logic [1:0] nx;
        nx = 2'b00;
        case (ph)
            2'b00:   nx = to_right ? 2'b10 : 2'b01;
            2'b10:   nx = to_right ? 2'b11 : 2'b00;
            2'b11:   nx = to_right ? 2'b01 : 2'b10;
            default: nx = to_right ? 2'b00 : 2'b11;
        endcase
        return nx;
    endfunction

    logic [CHANNELS-1:0] r_s1, r_s2, l_s1, l_s2;

    // Two-stage synchroniser for the asynchronous buttons.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1 <= '0;
            r_s2 <= '0;
            l_s1 <= '0;
            l_s2 <= '0;
        end else begin
            r_s1 <= right;
            r_s2 <= r_s1;
            l_s1 <= left;
            l_s2 <= l_s1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        dir_t              dir, dir_nx, req;
        logic [1:0]        phase, phase_nx;
        logic [DIV_W-1:0]  count, count_nx;
        logic [SPD_W-1:0]  speed, speed_nx;
        logic [STEP_W-1:0] step_cnt, step_cnt_nx;
        logic              mov;
        logic              account;

        always_comb begin
            dir_nx      = dir;
            phase_nx    = phase;
            count_nx    = count;
            speed_nx    = speed;
            step_cnt_nx = step_cnt;
            account     = 1'b0;
            req         = IDLE;
            if (r_s2[ch] & ~l_s2[ch]) begin
                req = RUN_R;
            end else if (l_s2[ch] & ~r_s2[ch]) begin
                req = RUN_L;
            end

            case (dir)
                IDLE: begin
                    if (req != IDLE) begin
                        dir_nx   = req;
                        phase_nx = next_phase(phase, req == RUN_R);
                        count_nx = clkdiv;
                        account  = 1'b1;
                    end
                end
                default: begin
                    if (req == IDLE) begin
                        dir_nx      = IDLE;
                        count_nx    = '0;
                        speed_nx    = '0;
                        step_cnt_nx = '0;
                    end else if (req != dir) begin
                        dir_nx      = req;
                        phase_nx    = next_phase(phase, req == RUN_R);
                        count_nx    = clkdiv;
                        speed_nx    = '0;
                        step_cnt_nx = '0;
                    end else if (count != '0) begin
                        count_nx = count - DIV_W'(1);
                    end else begin
                        phase_nx = next_phase(phase, dir == RUN_R);
                        count_nx = clkdiv >> speed;
                        account  = 1'b1;
                    end
                end
            endcase

            // Step bookkeeping; the reload above already used the pre-update speed.
            if (account) begin
                if (step_cnt == STEP_LAST) begin
                    if (speed < SPD_MAX) begin
                        speed_nx    = speed + SPD_W'(1);
                        step_cnt_nx = '0;
                    end
                end else begin
                    step_cnt_nx = step_cnt + STEP_W'(1);
                end
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                dir      <= IDLE;
                phase    <= 2'b00;
                count    <= '0;
                speed    <= '0;
                step_cnt <= '0;
                mov      <= 1'b0;
            end else begin
                dir      <= dir_nx;
                phase    <= phase_nx;
                count    <= count_nx;
                speed    <= speed_nx;
                step_cnt <= step_cnt_nx;
                mov      <= (dir_nx != IDLE);
            end
        end

        assign steer[2*ch +: 2] = phase;
        assign moving[ch]       = mov;
    end

endmodule

// File: tb/tb_joy2quad_accel.sv
// Randomised and directed bench for joy2quad_accel: an event-time reference model queues the
// expected outputs of every clock edge and a monitor compares them against the DUT.
module tb_joy2quad_accel;

    localparam int unsigned CH = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned AS = 4;
    localparam int unsigned MS = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     clkdiv = 16'd3;
    logic [CH-1:0]     right = '0;
    logic [CH-1:0]     left  = '0;
    logic [2*CH-1:0]   steer;
    logic [CH-1:0]     moving;

    joy2quad_accel #(
        .CHANNELS(CH), .DIV_W(DW), .ACCEL_STEPS(AS), .MAX_SPEED(MS)
    ) dut (
        .CLK(clk), .RESET(rst), .clkdiv(clkdiv), .right(right), .left(left),
        .steer(steer), .moving(moving)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [3*CH-1:0] exp_q[$];

    // Reference state: direction (0 none, 1 right, 2 left), ring position, absolute cycle of
    // the next due step, and number of steps that count toward acceleration in this run.
    int            dirm[CH];
    int            pos[CH];
    longint        nxt[CH];
    int            acc[CH];
    longint        cyc = 0;
    logic [CH-1:0] hr[$];
    logic [CH-1:0] hl[$];

    function automatic logic [1:0] ring_code(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [2*CH-1:0] es;
        logic [CH-1:0]   em;
        logic [CH-1:0]   er;
        logic [CH-1:0]   el;
        int              rq;
        int              spd;
        cyc = cyc + 1;
        if (rst) begin
            for (int n = 0; n < CH; n++) begin
                dirm[n] = 0;
                pos[n]  = 0;
                acc[n]  = 0;
                nxt[n]  = 0;
            end
            hr = {};
            hl = {};
            hr.push_back('0);
            hr.push_back('0);
            hl.push_back('0);
            hl.push_back('0);
        end else begin
            // Button level sampled two edges ago is what this edge acts on.
            er = hr.pop_front();
            el = hl.pop_front();
            hr.push_back(right);
            hl.push_back(left);
            for (int n = 0; n < CH; n++) begin
                rq = (er[n] && !el[n]) ? 1 : ((el[n] && !er[n]) ? 2 : 0);
                if (dirm[n] == 0) begin
                    if (rq != 0) begin
                        dirm[n] = rq;
                        pos[n]  = (rq == 1) ? (pos[n] + 1) % 4 : (pos[n] + 3) % 4;
                        nxt[n]  = cyc + longint'(clkdiv) + 1;
                        acc[n]  = 1;
                    end
                end else if (rq == 0) begin
                    dirm[n] = 0;
                end else if (rq != dirm[n]) begin
                    dirm[n] = rq;
                    pos[n]  = (rq == 1) ? (pos[n] + 1) % 4 : (pos[n] + 3) % 4;
                    nxt[n]  = cyc + longint'(clkdiv) + 1;
                    acc[n]  = 0;
                end else if (cyc == nxt[n]) begin
                    pos[n] = (rq == 1) ? (pos[n] + 1) % 4 : (pos[n] + 3) % 4;
                    spd    = acc[n] / AS;
                    if (spd > MS) spd = MS;
                    nxt[n] = cyc + longint'(int'(clkdiv) >> spd) + 1;
                    acc[n] = acc[n] + 1;
                end
            end
        end
        for (int n = 0; n < CH; n++) begin
            es[2*n +: 2] = ring_code(pos[n]);
            em[n]        = (dirm[n] != 0);
        end
        exp_q.push_back({es, em});
    end

    always @(negedge clk) begin : monitor
        logic [3*CH-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({steer, moving} !== e) begin
                fails++;
                $display("FAIL outputs t=%0t got steer=%b moving=%b expected steer=%b moving=%b",
                         $time, steer, moving, e[3*CH-1:CH], e[CH-1:0]);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_async_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (steer !== '0 || moving !== '0) begin
            fails++;
            $display("FAIL %s got steer=%b moving=%b expected 0000/00", name, steer, moving);
        end
        right = '0;
        left  = '0;
        wait_cycles(3);
        rst = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        rst = 1'b0;
        // Get a channel moving, then hit reset between edges.
        right[1] = 1'b1;
        wait_cycles(12);
        check_async_reset("reset_mid_run");
        wait_cycles(100);

        right[0] = 1'b1;
        wait_cycles(30);
        right[0] = 1'b0;
        wait_cycles(6);

        left[1] = 1'b1;
        wait_cycles(20);
        left[1] = 1'b0;
        wait_cycles(6);

        left[0]  = 1'b1;
        right[0] = 1'b1;
        wait_cycles(10);
        left[0] = 1'b0;
        wait_cycles(15);
        right[0] = 1'b0;
        wait_cycles(6);

        right[0] = 1'b1;
        wait_cycles(40);
        right[0] = 1'b0;
        left[0]  = 1'b1;
        wait_cycles(25);
        left[0] = 1'b0;
        wait_cycles(6);

        clkdiv   = '0;
        right[0] = 1'b1;
        left[1]  = 1'b1;
        wait_cycles(20);
        right = '0;
        left  = '0;
        wait_cycles(6);

        clkdiv = 16'd3;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int n = 0; n < CH; n++) begin
                if ($urandom_range(0, 11) == 0) right[n] = ~right[n];
                if ($urandom_range(0, 11) == 0) left[n]  = ~left[n];
            end
            if ($urandom_range(0, 49) == 0) clkdiv = DW'($urandom_range(0, 6));
        end
        right = '0;
        left  = '0;
        wait_cycles(5);
        check_async_reset("reset_after_random");
        wait_cycles(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
